stream_fifo_wrapper: RTL and testbench

- Synchronous single-clock FIFO with valid/ready handshakes on both sides.
- Buffers byte streams between the testbench host interface and the decoder core, one instance per direction (input and output).
- First-word-fall-through: head entry is presented on output_data whenever output_valid is high.

---
 rtl/stream_fifo_wrapper.sv | 97 +++++++++
 tb/tb_stream_fifo_wrapper.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_wrapper.sv
// stream_fifo_wrapper
// ----------------------------------------------------------------------------
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on
// both sides. It buffers byte streams between the host interface and the
// decoder core. One instance is used for each direction.
//
// Ports
//   clk           rising-edge clock for all state
//   reset         synchronous reset, active low (asserted when 0)
//   input_data    write data from upstream
//   input_valid   upstream offers input_data this cycle
//   input_ready   FIFO accepts a word this cycle (not full, not in reset)
//   output_data   head-of-queue word, meaningful only while output_valid
//   output_valid  FIFO holds at least one word
//   output_ready  downstream takes the head word this cycle
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  number of storage entries, any integer >= 2 (need not be 2^n)
// ----------------------------------------------------------------------------
module stream_fifo_wrapper #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_data,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [WIDTH-1:0] output_data,
    output logic             output_valid,
    input  logic             output_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;

    // DEPTH need not be a power of two, so the pointer wraps explicitly at the
    // last entry instead of relying on natural binary rollover.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Both flags depend only on the registered count. That means there is no
    // combinational path from input_valid to output_valid. There is also no
    // path from output_ready to input_ready, so a full FIFO never passes data
    // straight through. Holding input_ready low during reset stops upstream
    // from believing a word was taken while the FIFO is being cleared.
    assign input_ready  = reset && (count != FULL_COUNT);
    assign output_valid = (count != '0);
    assign output_data  = storage[rd_ptr];

    assign push = input_valid && input_ready;
    assign pop  = output_valid && output_ready && reset;

    // Storage is written on every accepted push. It is never cleared, because
    // the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= input_data;
        end
    end

    // Pointers and occupancy. A push and a pop in the same cycle leave the
    // count unchanged while both pointers advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_fifo_wrapper.sv
// tb_stream_fifo_wrapper
// ----------------------------------------------------------------------------
// Self-checking bench for stream_fifo_wrapper. It uses two instances:
//   dut_big    DEPTH=128. Reset, single word, fill/drain, streaming and
//              mid-stream reset are run against it.
//   dut_small  DEPTH=5. Full/empty corner cases and randomized
//              wrap-around traffic are run against it.
// Each instance is mirrored by a queue model that follows the handshake rules
// directly. Every cycle, input_ready, output_valid and output_data (when
// valid) are compared against that model. Words leaving each DUT are also
// recorded and checked against the order in which they were sent.
// ----------------------------------------------------------------------------
module tb_stream_fifo_wrapper;

    localparam int WIDTH       = 8;
    localparam int BIG_DEPTH   = 128;
    localparam int SMALL_DEPTH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [WIDTH-1:0] b_in_data;
    logic             b_in_valid;
    logic             b_in_ready;
    logic [WIDTH-1:0] b_out_data;
    logic             b_out_valid;
    logic             b_out_ready;

    logic [WIDTH-1:0] s_in_data;
    logic             s_in_valid;
    logic             s_in_ready;
    logic [WIDTH-1:0] s_out_data;
    logic             s_out_valid;
    logic             s_out_ready;

    stream_fifo_wrapper #(.WIDTH(WIDTH), .DEPTH(BIG_DEPTH)) dut_big (
        .clk          (clk),
        .reset        (reset),
        .input_data   (b_in_data),
        .input_valid  (b_in_valid),
        .input_ready  (b_in_ready),
        .output_data  (b_out_data),
        .output_valid (b_out_valid),
        .output_ready (b_out_ready)
    );

    stream_fifo_wrapper #(.WIDTH(WIDTH), .DEPTH(SMALL_DEPTH)) dut_small (
        .clk          (clk),
        .reset        (reset),
        .input_data   (s_in_data),
        .input_valid  (s_in_valid),
        .input_ready  (s_in_ready),
        .output_data  (s_out_data),
        .output_valid (s_out_valid),
        .output_ready (s_out_ready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model queues, and words actually seen leaving each DUT.
    logic [WIDTH-1:0] q_big[$];
    logic [WIDTH-1:0] q_small[$];
    logic [WIDTH-1:0] got_big[$];
    logic [WIDTH-1:0] got_small[$];
    bit               s_accept;

    typedef struct {
        logic             rst;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             e_ready;
        logic             e_valid;
        logic             chk_data;
        logic [WIDTH-1:0] e_data;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic iv,
                                 input logic [WIDTH-1:0] d, input logic ordy);
        reset       = rst;
        b_in_valid  = iv;
        b_in_data   = d;
        b_out_ready = ordy;
    endtask

    task automatic applySmall(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        s_in_valid  = iv;
        s_in_data   = d;
        s_out_ready = ordy;
    endtask

    // One clock cycle. The model decides its handshakes from its own
    // occupancy before the edge. DUT outputs are then checked 1 time unit
    // after the edge.
    task automatic tick();
        bit b_push, b_pop, s_push, s_pop;
        b_push = reset && b_in_valid && (q_big.size() < BIG_DEPTH);
        b_pop  = reset && b_out_ready && (q_big.size() > 0);
        s_push = reset && s_in_valid && (q_small.size() < SMALL_DEPTH);
        s_pop  = reset && s_out_ready && (q_small.size() > 0);
        s_accept = s_push;
        if (reset && b_out_valid && b_out_ready) got_big.push_back(b_out_data);
        if (reset && s_out_valid && s_out_ready) got_small.push_back(s_out_data);
        @(posedge clk);
        if (!reset) begin
            q_big.delete();
            q_small.delete();
        end else begin
            if (b_pop)  void'(q_big.pop_front());
            if (b_push) q_big.push_back(b_in_data);
            if (s_pop)  void'(q_small.pop_front());
            if (s_push) q_small.push_back(s_in_data);
        end
        #1;
        checkOutput("big_ready", b_in_ready, reset && (q_big.size() < BIG_DEPTH));
        checkOutput("big_valid", b_out_valid, q_big.size() > 0);
        if (q_big.size() > 0) checkOutput("big_data", b_out_data, q_big[0]);
        checkOutput("small_ready", s_in_ready, reset && (q_small.size() < SMALL_DEPTH));
        checkOutput("small_valid", s_out_valid, q_small.size() > 0);
        if (q_small.size() > 0) checkOutput("small_data", s_out_data, q_small[0]);
    endtask

    task automatic drainBig(input int budget);
        int n;
        n = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        while (b_out_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput("big_drain_done", b_out_valid, 1'b0);
        b_out_ready = 1'b0;
    endtask

    task automatic drainSmall(input int budget);
        int n;
        n = 0;
        applySmall(1'b0, '0, 1'b1);
        while (s_out_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput("small_drain_done", s_out_valid, 1'b0);
        s_out_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] sent[$];
        int idx;
        int cycles;

        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applySmall(1'b0, '0, 1'b0);

        // Reset for two cycles, idle, then a single word 0xA5 pushed, held, popped.
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            tick();
            checkOutput($sformatf("vec%0d_ready", i), b_in_ready, vecs[i].e_ready);
            checkOutput($sformatf("vec%0d_valid", i), b_out_valid, vecs[i].e_valid);
            if (vecs[i].chk_data) checkOutput($sformatf("vec%0d_data", i), b_out_data, vecs[i].e_data);
        end

        // Fill to full, then try one extra write, then drain in order.
        $display("[TB] fill and drain DEPTH=%0d", BIG_DEPTH);
        got_big.delete();
        for (int i = 0; i < BIG_DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
            tick();
        end
        checkOutput("full_ready", b_in_ready, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
        tick();
        checkOutput("full_extra_ready", b_in_ready, 1'b0);
        drainBig(BIG_DEPTH + 4);
        checkOutput("fill_count", got_big.size(), BIG_DEPTH);
        for (int i = 0; i < BIG_DEPTH; i++) begin
            checkOutput($sformatf("fill_word%0d", i), got_big[i], 8'(i));
        end

        // Preload 1..3, then stream 4..20 with push and pop every cycle.
        $display("[TB] streaming at partial fill");
        got_big.delete();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
            tick();
        end
        for (int i = 4; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i), 1'b1);
            tick();
            checkOutput("stream_occupancy", q_big.size(), 3);
        end
        drainBig(10);
        checkOutput("stream_count", got_big.size(), 20);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("stream_word%0d", i), got_big[i], 8'(i + 1));
        end

        // Reset with 10 words queued, then confirm the next push comes out first.
        $display("[TB] reset mid-stream");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("midrst_valid", b_out_valid, 1'b0);
        checkOutput("midrst_ready", b_in_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("postrst_valid", b_out_valid, 1'b0);
        checkOutput("postrst_ready", b_in_ready, 1'b1);
        got_big.delete();
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        tick();
        checkOutput("postrst_count", got_big.size(), 1);
        checkOutput("postrst_first", got_big[0], 8'h3C);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);

        // Small FIFO: push into empty while downstream is ready, so only the push happens.
        $display("[TB] small FIFO corners DEPTH=%0d", SMALL_DEPTH);
        got_small.delete();
        applySmall(1'b1, 8'h77, 1'b1);
        tick();
        checkOutput("empty_both_valid", s_out_valid, 1'b1);
        checkOutput("empty_both_data", s_out_data, 8'h77);
        checkOutput("empty_both_nopop", got_small.size(), 0);
        drainSmall(4);
        got_small.delete();
        for (int i = 0; i < SMALL_DEPTH; i++) begin
            applySmall(1'b1, 8'(8'h10 + i), 1'b0);
            tick();
        end
        checkOutput("small_full_ready", s_in_ready, 1'b0);
        applySmall(1'b1, 8'hEE, 1'b1);
        tick();
        checkOutput("full_both_ready", s_in_ready, 1'b1);
        drainSmall(8);
        checkOutput("full_both_count", got_small.size(), SMALL_DEPTH);
        for (int i = 0; i < SMALL_DEPTH; i++) begin
            checkOutput($sformatf("full_both_word%0d", i), got_small[i], 8'(8'h10 + i));
        end

        // Randomly gated traffic through the 5-entry FIFO to exercise wrap-around.
        $display("[TB] random wrap-around traffic");
        got_small.delete();
        for (int i = 0; i < 23; i++) sent.push_back(8'((i * 37 + 11) & 8'hFF));
        idx = 0;
        cycles = 0;
        while (got_small.size() < 23 && cycles < 2000) begin
            applySmall((idx < 23) && ($urandom_range(0, 2) != 0),
                       (idx < 23) ? sent[idx] : 8'h00,
                       $urandom_range(0, 2) != 0);
            tick();
            if (s_accept) idx++;
            cycles++;
        end
        checkOutput("wrap_no_timeout", cycles < 2000, 1'b1);
        applySmall(1'b0, '0, 1'b1);
        tick();
        checkOutput("wrap_count", got_small.size(), 23);
        for (int i = 0; i < 23; i++) begin
            checkOutput($sformatf("wrap_word%0d", i), got_small[i], sent[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
